// File: rtl/cpu_pkg.sv
// Shared definitions for the control sequencer slice.
// Holds the instruction field positions, opcode constants, ALU select bit
// indices, FSM state encoding, the decoded-instruction struct and the
// opcode -> ALU one-hot index mapping.
package cpu_pkg;

  // Instruction field bit positions
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RA_HI  = 26;
  localparam int RA_LO  = 23;
  localparam int RB_HI  = 22;
  localparam int RB_LO  = 19;
  localparam int RC_HI  = 18;
  localparam int RC_LO  = 15;

  // Opcodes; anything above OP_NOT is illegal
  localparam logic [4:0] OP_AND  = 5'd0;
  localparam logic [4:0] OP_OR   = 5'd1;
  localparam logic [4:0] OP_ADD  = 5'd2;
  localparam logic [4:0] OP_SUB  = 5'd3;
  localparam logic [4:0] OP_SHR  = 5'd4;
  localparam logic [4:0] OP_SHRA = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_MUL  = 5'd9;
  localparam logic [4:0] OP_DIV  = 5'd10;
  localparam logic [4:0] OP_NEG  = 5'd11;
  localparam logic [4:0] OP_NOT  = 5'd12;

  // alu_sel bit indices (ALU ordering differs from opcode ordering)
  localparam int ALU_W    = 13;
  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_MUL  = 4'd4;
  localparam logic [3:0] ALU_DIV  = 4'd5;
  localparam logic [3:0] ALU_SHR  = 4'd6;
  localparam logic [3:0] ALU_SHRA = 4'd7;
  localparam logic [3:0] ALU_SHL  = 4'd8;
  localparam logic [3:0] ALU_ROR  = 4'd9;
  localparam logic [3:0] ALU_ROL  = 4'd10;
  localparam logic [3:0] ALU_NEG  = 4'd11;
  localparam logic [3:0] ALU_NOT  = 4'd12;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_T0   = 3'd1;
  localparam logic [2:0] ST_T1   = 3'd2;
  localparam logic [2:0] ST_T2   = 3'd3;
  localparam logic [2:0] ST_T3   = 3'd4;
  localparam logic [2:0] ST_T4   = 3'd5;
  localparam logic [2:0] ST_T5   = 3'd6;
  localparam logic [2:0] ST_HALT = 3'd7;

  typedef struct packed {
    logic [ALU_W-1:0] alu_sel;
    logic [15:0]      ra_oh;
    logic [15:0]      rb_oh;
    logic [15:0]      rc_oh;
    logic             is_muldiv;
    logic             is_unary;
    logic             illegal;
  } dec_t;

  function automatic logic [3:0] op_to_alu_idx(input logic [4:0] op);
    case (op)
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_SHR:  return ALU_SHR;
      OP_SHRA: return ALU_SHRA;
      OP_SHL:  return ALU_SHL;
      OP_ROR:  return ALU_ROR;
      OP_ROL:  return ALU_ROL;
      OP_MUL:  return ALU_MUL;
      OP_DIV:  return ALU_DIV;
      OP_NEG:  return ALU_NEG;
      OP_NOT:  return ALU_NOT;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath bundle.
//   run, IR            : datapath/host -> sequencer
//   Rout, Rin, alu_sel : one-hot register and ALU selects
//   IncPC..HIin        : datapath strobes
//   done, halted       : status
// master = sequencer side, slave = datapath side.
interface control_sequencer_if;
  import cpu_pkg::*;

  logic             run;
  logic [31:0]      IR;
  logic [15:0]      Rout;
  logic [15:0]      Rin;
  logic [ALU_W-1:0] alu_sel;
  logic             IncPC, PCin, MARin, MDRin, Read, MDRout, IRin;
  logic             Yin, Zin, Zlowout, Zhighout, LOin, HIin;
  logic             done;
  logic             halted;

  modport master (
    input  run, IR,
    output Rout, Rin, alu_sel, IncPC, PCin, MARin, MDRin, Read, MDRout, IRin,
           Yin, Zin, Zlowout, Zhighout, LOin, HIin, done, halted
  );

  modport slave (
    output run, IR,
    input  Rout, Rin, alu_sel, IncPC, PCin, MARin, MDRin, Read, MDRout, IRin,
           Yin, Zin, Zlowout, Zhighout, LOin, HIin, done, halted
  );
endinterface

// File: rtl/control_sequencer_decoder.sv
// instr_decoder: purely combinational instruction decode.
//   i_ir  : instruction register contents
//   o_dec : ALU one-hot, Ra/Rb/Rc one-hots, is_muldiv/is_unary/illegal flags
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [31:0] i_ir,
  output dec_t        o_dec
);

  logic [4:0] w_op;
  logic [3:0] w_ra, w_rb, w_rc;
  logic       w_unused_ir;

  assign w_op = i_ir[OPC_HI:OPC_LO];
  assign w_ra = i_ir[RA_HI:RA_LO];
  assign w_rb = i_ir[RB_HI:RB_LO];
  assign w_rc = i_ir[RC_HI:RC_LO];
  // Low bits carry immediates for other instruction classes.
  assign w_unused_ir = ^i_ir[RC_LO-1:0];

  always_comb begin
    o_dec = '0;
    o_dec.illegal = (w_op > OP_NOT);
    // An illegal opcode must not select any ALU operation.
    if (!o_dec.illegal) o_dec.alu_sel[op_to_alu_idx(w_op)] = 1'b1;
    o_dec.ra_oh[w_ra] = 1'b1;
    o_dec.rb_oh[w_rb] = 1'b1;
    o_dec.rc_oh[w_rc] = 1'b1;
    o_dec.is_muldiv = (w_op == OP_MUL) || (w_op == OP_DIV);
    o_dec.is_unary  = (w_op == OP_NEG) || (w_op == OP_NOT);
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit for a single-bus datapath.
//   clk   : system clock, rising edge
//   reset : asynchronous active-high; forces IDLE and all outputs low
//   bus   : control_sequencer_if.master (run/IR in, selects/strobes/status out)
// Fetch is T0/T1, operand B to Y in T2, ALU op in T3, writeback in T4
// (MUL/DIV write LO in T4 and HI in T5). Illegal opcodes park in HALT.
module control_sequencer
  import cpu_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  control_sequencer_if.master bus
);

  logic [2:0] r_state;
  logic [2:0] w_next;
  dec_t       w_dec;

  instr_decoder u_dec (
    .i_ir  (bus.IR),
    .o_dec (w_dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: w_next = bus.run ? ST_T0 : ST_IDLE;
      ST_T0:   w_next = ST_T1;
      ST_T1:   w_next = ST_T2;
      ST_T2:   w_next = w_dec.illegal ? ST_HALT : ST_T3;
      ST_T3:   w_next = ST_T4;
      // run is only sampled at the final execute state, so dropping it
      // mid-instruction never aborts.
      ST_T4:   w_next = w_dec.is_muldiv ? ST_T5 : (bus.run ? ST_T0 : ST_IDLE);
      ST_T5:   w_next = bus.run ? ST_T0 : ST_IDLE;
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_IDLE;
    endcase
  end

  // Moore outputs: decoded from state (and IR from T2 on) only.
  always_comb begin
    bus.Rout     = '0;
    bus.Rin      = '0;
    bus.alu_sel  = '0;
    bus.IncPC    = 1'b0;
    bus.PCin     = 1'b0;
    bus.MARin    = 1'b0;
    bus.MDRin    = 1'b0;
    bus.Read     = 1'b0;
    bus.MDRout   = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.Zin      = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.Zhighout = 1'b0;
    bus.LOin     = 1'b0;
    bus.HIin     = 1'b0;
    bus.done     = 1'b0;
    bus.halted   = 1'b0;
    case (r_state)
      ST_T0: begin
        bus.IncPC = 1'b1;
        bus.PCin  = 1'b1;
        bus.MARin = 1'b1;
        bus.Read  = 1'b1;
        bus.MDRin = 1'b1;
      end
      ST_T1: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      ST_T2: begin
        if (!w_dec.illegal) begin
          bus.Rout = w_dec.rb_oh;
          bus.Yin  = 1'b1;
        end
      end
      ST_T3: begin
        // Unary ops take their single operand from Rb; Y is a don't-care.
        bus.Rout    = w_dec.is_unary ? w_dec.rb_oh : w_dec.rc_oh;
        bus.alu_sel = w_dec.alu_sel;
        bus.Zin     = 1'b1;
      end
      ST_T4: begin
        bus.Zlowout = 1'b1;
        if (w_dec.is_muldiv) begin
          bus.LOin = 1'b1;
        end else begin
          bus.Rin  = w_dec.ra_oh;
          bus.done = 1'b1;
        end
      end
      ST_T5: begin
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
        bus.done     = 1'b1;
      end
      ST_HALT: bus.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer.
module tb_control_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  control_sequencer_if bus_if ();

  control_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe vector order: IncPC PCin MARin MDRin Read MDRout IRin Yin Zin
  //                      Zlowout Zhighout LOin HIin
  localparam logic [12:0] S_FETCH0 = 13'h1F00;
  localparam logic [12:0] S_FETCH1 = 13'h00C0;
  localparam logic [12:0] S_YIN    = 13'h0020;
  localparam logic [12:0] S_ZIN    = 13'h0010;
  localparam logic [12:0] S_ZLO    = 13'h0008;
  localparam logic [12:0] S_ZHI    = 13'h0004;
  localparam logic [12:0] S_LOIN   = 13'h0002;
  localparam logic [12:0] S_HIIN   = 13'h0001;

  localparam logic [31:0] IR_SHRA = 32'h2A1B8000; // SHRA R4,R3,R7
  localparam logic [31:0] IR_MUL  = 32'h48128000; // MUL Rb=2, Rc=5
  localparam logic [31:0] IR_NEG  = 32'h58B48000; // NEG R1,R6 (Rc=9 ignored)
  localparam logic [31:0] IR_ILL  = 32'hF8000000; // opcode 31
  localparam logic [31:0] IR_ADD  = 32'h11890000; // ADD R3,R1,R2

  function automatic logic [59:0] mk(input logic [15:0] rout, input logic [15:0] rin,
                                     input logic [12:0] alu, input logic [12:0] stb,
                                     input logic dn, input logic hl);
    return {rout, rin, alu, stb, dn, hl};
  endfunction

  function automatic logic [59:0] snap();
    return {bus_if.Rout, bus_if.Rin, bus_if.alu_sel,
            bus_if.IncPC, bus_if.PCin, bus_if.MARin, bus_if.MDRin, bus_if.Read,
            bus_if.MDRout, bus_if.IRin, bus_if.Yin, bus_if.Zin,
            bus_if.Zlowout, bus_if.Zhighout, bus_if.LOin, bus_if.HIin,
            bus_if.done, bus_if.halted};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [59:0] got;
    reset = 1'b1;
    bus_if.run = 1'b0;
    bus_if.IR  = 32'h0;
    #3;
    got = snap();
    checks++;
    if (got !== 60'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", got, 60'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      got = snap();
      checks++;
      if (got !== 60'h0) begin
        failures++;
        $display("FAIL idle_hold cyc=%0d got=%h exp=%h", i, got, 60'h0);
      end
    end
  endtask

  // Pulses run for one cycle; checks T0..T4 and the following IDLE.
  task automatic test_shra();
    logic [59:0] exp_v [6];
    logic [59:0] got;
    exp_v[0] = mk(16'h0, 16'h0, 13'h0, S_FETCH0, 1'b0, 1'b0);
    exp_v[1] = mk(16'h0, 16'h0, 13'h0, S_FETCH1, 1'b0, 1'b0);
    exp_v[2] = mk(16'h0008, 16'h0, 13'h0, S_YIN, 1'b0, 1'b0);
    exp_v[3] = mk(16'h0080, 16'h0, 13'h0080, S_ZIN, 1'b0, 1'b0);
    exp_v[4] = mk(16'h0, 16'h0010, 13'h0, S_ZLO, 1'b1, 1'b0);
    exp_v[5] = 60'h0;
    @(negedge clk);
    bus_if.IR  = IR_SHRA;
    bus_if.run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      got = snap();
      checks++;
      if (got !== exp_v[i]) begin
        failures++;
        $display("FAIL shra_cyc%0d got=%h exp=%h", i, got, exp_v[i]);
      end
      if (i == 0) begin
        @(negedge clk);
        bus_if.run = 1'b0;
      end
    end
  endtask

  task automatic test_mul();
    logic [59:0] exp_v [5];
    logic [59:0] got;
    exp_v[0] = mk(16'h0004, 16'h0, 13'h0, S_YIN, 1'b0, 1'b0);
    exp_v[1] = mk(16'h0020, 16'h0, 13'h0010, S_ZIN, 1'b0, 1'b0);
    exp_v[2] = mk(16'h0, 16'h0, 13'h0, S_ZLO | S_LOIN, 1'b0, 1'b0);
    exp_v[3] = mk(16'h0, 16'h0, 13'h0, S_ZHI | S_HIIN, 1'b1, 1'b0);
    exp_v[4] = 60'h0;
    @(negedge clk);
    bus_if.IR  = IR_MUL;
    bus_if.run = 1'b1;
    step();
    @(negedge clk);
    bus_if.run = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      got = snap();
      checks++;
      if (got !== exp_v[i]) begin
        failures++;
        $display("FAIL mul_cyc%0d got=%h exp=%h", i + 2, got, exp_v[i]);
      end
    end
  endtask

  task automatic test_neg();
    logic [59:0] exp_v [4];
    logic [59:0] got;
    exp_v[0] = mk(16'h0040, 16'h0, 13'h0, S_YIN, 1'b0, 1'b0);
    exp_v[1] = mk(16'h0040, 16'h0, 13'h0800, S_ZIN, 1'b0, 1'b0);
    exp_v[2] = mk(16'h0, 16'h0002, 13'h0, S_ZLO, 1'b1, 1'b0);
    exp_v[3] = 60'h0;
    @(negedge clk);
    bus_if.IR  = IR_NEG;
    bus_if.run = 1'b1;
    step();
    @(negedge clk);
    bus_if.run = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      got = snap();
      checks++;
      if (got !== exp_v[i]) begin
        failures++;
        $display("FAIL neg_cyc%0d got=%h exp=%h", i + 2, got, exp_v[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [59:0] got;
    logic [59:0] halt_v;
    halt_v = mk(16'h0, 16'h0, 13'h0, 13'h0, 1'b0, 1'b1);
    @(negedge clk);
    bus_if.IR  = IR_ILL;
    bus_if.run = 1'b1;
    step();
    step();
    step();
    got = snap();
    checks++;
    if (got !== 60'h0) begin
      failures++;
      $display("FAIL illegal_t2 got=%h exp=%h", got, 60'h0);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      got = snap();
      checks++;
      if (got !== halt_v) begin
        failures++;
        $display("FAIL halt_sticky cyc=%0d got=%h exp=%h", i, got, halt_v);
      end
      @(negedge clk);
      bus_if.run = ~bus_if.run;
    end
    bus_if.run = 1'b0;
    reset = 1'b1;
    #1;
    got = snap();
    checks++;
    if (got !== 60'h0) begin
      failures++;
      $display("FAIL halt_reset got=%h exp=%h", got, 60'h0);
    end
    #1;
    reset = 1'b0;
    step();
    got = snap();
    checks++;
    if (got !== 60'h0) begin
      failures++;
      $display("FAIL halt_after_reset got=%h exp=%h", got, 60'h0);
    end
  endtask

  task automatic test_async_reset();
    logic [59:0] got;
    logic [59:0] t3_v;
    t3_v = mk(16'h0004, 16'h0, 13'h0004, S_ZIN, 1'b0, 1'b0);
    @(negedge clk);
    bus_if.IR  = IR_ADD;
    bus_if.run = 1'b1;
    step();
    @(negedge clk);
    bus_if.run = 1'b0;
    step();
    step();
    step();
    got = snap();
    checks++;
    if (got !== t3_v) begin
      failures++;
      $display("FAIL add_t3 got=%h exp=%h", got, t3_v);
    end
    #2;
    reset = 1'b1;
    #1;
    got = snap();
    checks++;
    if (got !== 60'h0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", got, 60'h0);
    end
    #2;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      got = snap();
      checks++;
      if (got !== 60'h0) begin
        failures++;
        $display("FAIL post_reset cyc=%0d got=%h exp=%h", i, got, 60'h0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [59:0] exp_v [11];
    logic [59:0] got;
    int          done_cnt;
    done_cnt = 0;
    for (int k = 0; k < 2; k++) begin
      exp_v[k*5+0] = mk(16'h0, 16'h0, 13'h0, S_FETCH0, 1'b0, 1'b0);
      exp_v[k*5+1] = mk(16'h0, 16'h0, 13'h0, S_FETCH1, 1'b0, 1'b0);
      exp_v[k*5+2] = mk(16'h0002, 16'h0, 13'h0, S_YIN, 1'b0, 1'b0);
      exp_v[k*5+3] = mk(16'h0004, 16'h0, 13'h0004, S_ZIN, 1'b0, 1'b0);
      exp_v[k*5+4] = mk(16'h0, 16'h0008, 13'h0, S_ZLO, 1'b1, 1'b0);
    end
    exp_v[10] = 60'h0;
    @(negedge clk);
    bus_if.IR  = IR_ADD;
    bus_if.run = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step();
      got = snap();
      if (bus_if.done === 1'b1) done_cnt++;
      checks++;
      if (got !== exp_v[i]) begin
        failures++;
        $display("FAIL b2b_cyc%0d got=%h exp=%h", i, got, exp_v[i]);
      end
      if (i == 5) begin
        @(negedge clk);
        bus_if.run = 1'b0;
      end
    end
    checks++;
    if (done_cnt != 2) begin
      failures++;
      $display("FAIL b2b_done_count got=%0d exp=%0d", done_cnt, 2);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_shra();
    test_mul();
    test_neg();
    test_illegal();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
